// File: rtl/riscv_m_unit_xl.sv
// RISC-V M-extension coprocessor on a PCPI-style port: XLEN 32/64 with RV64 W-ops,
// a MUL_STAGES-deep multiplier pipeline and a restoring divider retiring DIV_BITS bits per cycle.
module riscv_m_unit_xl #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2,
   parameter int DIV_BITS   = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            valid,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            wr,
   output logic [XLEN-1:0] rd,
   output logic            busy,
   output logic            ready,
   output logic [1:0]      o_dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam bit         HAS_W  = (XLEN == 64);
   localparam int         PW     = 2 * XLEN + 2;

   logic [1:0]      r_state;
   logic            r_block;
   logic [6:0]      r_cnt;
   logic [2:0]      r_f3;
   logic            r_w;
   logic            r_special;
   logic            r_qneg;
   logic            r_rneg;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_dvs;
   logic [XLEN-1:0] r_rd;
   logic [2*XLEN-1:0] r_mpipe [MUL_STAGES];

   logic [6:0]      w_opcode;
   logic [6:0]      w_f7;
   logic [2:0]      w_f3;
   logic            w_is_op;
   logic            w_is_w;
   logic            w_accept;
   logic            w_sgn_a;
   logic            w_sgn_b;
   logic [XLEN-1:0] w_ea;
   logic [XLEN-1:0] w_eb;
   logic signed [XLEN:0] w_ma;
   logic signed [XLEN:0] w_mb;
   logic signed [PW-1:0] w_prod;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic [XLEN-1:0] w_dvd;
   logic            w_div0;
   logic            w_ovf;
   logic [6:0]      w_iters;
   logic [XLEN:0]   w_sh;
   logic [XLEN-1:0] w_rem_n;
   logic [XLEN-1:0] w_quo_n;
   logic [XLEN-1:0] w_q_fix;
   logic [XLEN-1:0] w_r_fix;
   logic [XLEN-1:0] w_mul_raw;
   logic [XLEN-1:0] w_div_raw;
   logic [XLEN-1:0] w_res_raw;
   logic [XLEN-1:0] w_res;
   logic            w_unused_bits;

   assign w_opcode = instruction[6:0];
   assign w_f3     = instruction[14:12];
   assign w_f7     = instruction[31:25];
   assign w_is_op  = (w_opcode == 7'b0110011) && (w_f7 == 7'b0000001);
   assign w_is_w   = HAS_W && (w_opcode == 7'b0111011) && (w_f7 == 7'b0000001) &&
                     ((w_f3 == 3'b000) || w_f3[2]);
   // The block flag keeps a request still held through completion from being taken twice.
   assign w_accept = (r_state == S_IDLE) && valid && (w_is_op || w_is_w) && !r_block;

   assign w_sgn_a = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
   assign w_sgn_b = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);

   always_comb begin
      w_ea = rs1;
      w_eb = rs2;
      if (w_is_w) begin
         w_ea = w_sgn_a ? XLEN'($signed(rs1[31:0])) : XLEN'(rs1[31:0]);
         w_eb = w_sgn_b ? XLEN'($signed(rs2[31:0])) : XLEN'(rs2[31:0]);
      end
   end

   assign w_ma   = {w_sgn_a & w_ea[XLEN-1], w_ea};
   assign w_mb   = {w_sgn_b & w_eb[XLEN-1], w_eb};
   assign w_prod = PW'(w_ma) * PW'(w_mb);

   assign w_neg_a = w_sgn_a & w_ea[XLEN-1];
   assign w_neg_b = w_sgn_b & w_eb[XLEN-1];
   assign w_mag_a = w_neg_a ? -w_ea : w_ea;
   assign w_mag_b = w_neg_b ? -w_eb : w_eb;
   // A 32-bit dividend is left-aligned so every width shifts out of the same MSB.
   assign w_dvd   = w_is_w ? (w_mag_a << (XLEN - 32)) : w_mag_a;
   assign w_iters = w_is_w ? 7'(32 / DIV_BITS) : 7'(XLEN / DIV_BITS);
   assign w_div0  = w_is_w ? (w_eb[31:0] == 32'd0) : (w_eb == '0);
   assign w_ovf   = w_sgn_b && (w_is_w ?
                    ((w_ea[31:0] == 32'h8000_0000) && (w_eb[31:0] == 32'hFFFF_FFFF)) :
                    ((w_ea == {1'b1, {(XLEN-1){1'b0}}}) && (&w_eb)));

   always_comb begin
      w_rem_n = r_rem;
      w_quo_n = r_quo;
      w_sh    = '0;
      for (int k = 0; k < DIV_BITS; k++) begin
         w_sh    = {w_rem_n, w_quo_n[XLEN-1]};
         w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
         if (w_sh >= {1'b0, r_dvs}) begin
            w_sh       = w_sh - {1'b0, r_dvs};
            w_quo_n[0] = 1'b1;
         end
         w_rem_n = w_sh[XLEN-1:0];
      end
   end

   assign w_q_fix   = r_qneg ? -r_quo : r_quo;
   assign w_r_fix   = r_rneg ? -r_rem : r_rem;
   assign w_mul_raw = (r_f3[1:0] == 2'b00) ? r_mpipe[MUL_STAGES-1][XLEN-1:0] :
                                             r_mpipe[MUL_STAGES-1][2*XLEN-1:XLEN];
   // Special-case results are preloaded already corrected, so they skip the sign fix.
   assign w_div_raw = r_special ? (r_f3[1] ? r_rem : r_quo) : (r_f3[1] ? w_r_fix : w_q_fix);
   assign w_res_raw = (r_state == S_MUL) ? w_mul_raw : w_div_raw;
   assign w_res     = r_w ? XLEN'($signed(w_res_raw[31:0])) : w_res_raw;

   assign w_unused_bits = ^{instruction[24:15], instruction[11:7], w_prod[PW-1:2*XLEN]};

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mpipe[0] <= w_prod[2*XLEN-1:0];
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
         r_mpipe[i] <= r_mpipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state   <= S_IDLE;
         r_block   <= 1'b0;
         r_cnt     <= '0;
         r_f3      <= '0;
         r_w       <= 1'b0;
         r_special <= 1'b0;
         r_qneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_quo     <= '0;
         r_rem     <= '0;
         r_dvs     <= '0;
         r_rd      <= '0;
      end else begin
         r_block <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_f3 <= w_f3;
                  r_w  <= w_is_w;
                  if (w_f3[2]) begin
                     r_state   <= S_DIV;
                     r_cnt     <= w_iters;
                     r_special <= w_div0 | w_ovf;
                     r_qneg    <= w_neg_a ^ w_neg_b;
                     r_rneg    <= w_neg_a;
                     r_dvs     <= w_mag_b;
                     if (w_div0) begin
                        r_quo <= '1;
                        r_rem <= w_ea;
                     end else if (w_ovf) begin
                        r_quo <= w_ea;
                        r_rem <= '0;
                     end else begin
                        r_quo <= w_dvd;
                        r_rem <= '0;
                     end
                  end else begin
                     r_state <= S_MUL;
                     r_cnt   <= 7'(MUL_STAGES - 1);
                  end
               end
            end
            S_MUL: begin
               if (r_cnt == 7'd0) begin
                  r_rd    <= w_res;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 7'd1;
               end
            end
            S_DIV: begin
               if (r_special || (r_cnt == 7'd0)) begin
                  r_rd    <= w_res;
                  r_state <= S_DONE;
               end else begin
                  r_quo <= w_quo_n;
                  r_rem <= w_rem_n;
                  r_cnt <= r_cnt - 7'd1;
               end
            end
            default: begin
               r_rd      <= '0;
               r_special <= 1'b0;
               r_cnt     <= '0;
               r_block   <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign ready       = (r_state == S_DONE);
   assign wr          = ready;
   assign rd          = r_rd;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_riscv_m_unit_xl.sv
// Directed scoreboard bench for riscv_m_unit_xl: three instances (RV32 radix-2, RV32 radix-4, RV64)
// driven one at a time; a negedge monitor pops expected results and completion cycles.
module tb_riscv_m_unit_xl;

   typedef struct {
      int          dut;
      logic [63:0] rd;
      int          cyc;
      string       name;
   } exp_t;

   localparam logic [6:0] OP   = 7'b0110011;
   localparam logic [6:0] OPW  = 7'b0111011;
   localparam logic [6:0] F7M  = 7'b0000001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  valid_v = 3'b000;
   logic [31:0] instr = '0;
   logic [63:0] rs1 = '0;
   logic [63:0] rs2 = '0;
   logic [2:0]  wr_v, busy_v, ready_v;
   logic [31:0] rd0, rd1;
   logic [63:0] rd2;
   logic [1:0]  st0, st1, st2;
   logic [63:0] rd_a [3];
   logic [1:0]  st_a [3];

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   riscv_m_unit_xl #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(1)) u_dut0 (
      .clk(clk), .resetn(rst), .valid(valid_v[0]), .instruction(instr),
      .rs1(rs1[31:0]), .rs2(rs2[31:0]), .wr(wr_v[0]), .rd(rd0),
      .busy(busy_v[0]), .ready(ready_v[0]), .o_dbg_state(st0));

   riscv_m_unit_xl #(.XLEN(32), .MUL_STAGES(3), .DIV_BITS(2)) u_dut1 (
      .clk(clk), .resetn(rst), .valid(valid_v[1]), .instruction(instr),
      .rs1(rs1[31:0]), .rs2(rs2[31:0]), .wr(wr_v[1]), .rd(rd1),
      .busy(busy_v[1]), .ready(ready_v[1]), .o_dbg_state(st1));

   riscv_m_unit_xl #(.XLEN(64), .MUL_STAGES(2), .DIV_BITS(1)) u_dut2 (
      .clk(clk), .resetn(rst), .valid(valid_v[2]), .instruction(instr),
      .rs1(rs1), .rs2(rs2), .wr(wr_v[2]), .rd(rd2),
      .busy(busy_v[2]), .ready(ready_v[2]), .o_dbg_state(st2));

   assign rd_a[0] = {32'd0, rd0};
   assign rd_a[1] = {32'd0, rd1};
   assign rd_a[2] = rd2;
   assign st_a[0] = st0;
   assign st_a[1] = st1;
   assign st_a[2] = st2;

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      return {f7, 5'd2, 5'd1, f3, 5'd3, op};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: every completion must match the oldest outstanding expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ready_v[d]) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ready dut%0d: got rd=%h, expected no completion (cycle %0d)",
                        d, rd_a[d], cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk({e.name, " dut"}, 64'(d), 64'(e.dut));
               chk({e.name, " rd"}, rd_a[d], e.rd);
               chk({e.name, " ready_cycle"}, 64'(cyc), 64'(e.cyc));
               chk({e.name, " wr"}, 64'(wr_v[d]), 64'd1);
               chk({e.name, " busy"}, 64'(busy_v[d]), 64'd1);
            end
         end else begin
            chk($sformatf("dut%0d idle_rd", d), rd_a[d], 64'd0);
            chk($sformatf("dut%0d idle_wr", d), 64'(wr_v[d]), 64'd0);
         end
      end
   end

   // Driver: holds valid through ready and one cycle beyond, so the no-reaccept rule is exercised.
   task automatic run(input int d, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp_rd, input int lat, input string nm);
      exp_t e;
      int   k;
      @(negedge clk);
      instr = ins;
      rs1 = a;
      rs2 = b;
      valid_v[d] = 1'b1;
      e.dut = d;
      e.rd = exp_rd;
      e.cyc = cyc + 1 + lat;
      e.name = nm;
      exp_q.push_back(e);
      k = 0;
      @(negedge clk);
      while (!ready_v[d] && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " completed"}, 64'(ready_v[d]), 64'd1);
      if (!ready_v[d]) begin
         valid_v[d] = 1'b0;
         return;
      end
      @(negedge clk);
      @(negedge clk);
      chk({nm, " no_reaccept"}, 64'(busy_v[d]), 64'd0);
      valid_v[d] = 1'b0;
   endtask

   initial begin
      int busy_seen;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("dut%0d reset_busy", d), 64'(busy_v[d]), 64'd0);
         chk($sformatf("dut%0d reset_ready", d), 64'(ready_v[d]), 64'd0);
         chk($sformatf("dut%0d reset_state", d), 64'(st_a[d]), 64'd0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // RV32, 2-stage multiplier, radix-2 divider
      run(0, enc(OP, 3'b000, F7M), 64'h7,        64'hFFFF_FFFD, 64'hFFFF_FFEB, 2,  "mul_7_m3");
      run(0, enc(OP, 3'b011, F7M), 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 2,  "mulhu_ones");
      run(0, enc(OP, 3'b001, F7M), 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 2,  "mulh_minmin");
      run(0, enc(OP, 3'b010, F7M), 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 2,  "mulhsu_m1");
      run(0, enc(OP, 3'b101, F7M), 64'd100,      64'd7,         64'd14,        33, "divu_100_7");
      run(0, enc(OP, 3'b111, F7M), 64'd100,      64'd7,         64'd2,         33, "remu_100_7");
      run(0, enc(OP, 3'b100, F7M), 64'hFFFF_FF9C, 64'd7,        64'hFFFF_FFF2, 33, "div_m100_7");
      run(0, enc(OP, 3'b110, F7M), 64'hFFFF_FF9C, 64'd7,        64'hFFFF_FFFE, 33, "rem_m100_7");
      run(0, enc(OP, 3'b100, F7M), 64'd100,      64'd0,         64'hFFFF_FFFF, 1,  "div_by0");
      run(0, enc(OP, 3'b110, F7M), 64'h1234_5678, 64'd0,        64'h1234_5678, 1,  "rem_by0");
      run(0, enc(OP, 3'b100, F7M), 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1, "div_ovf");
      run(0, enc(OP, 3'b110, F7M), 64'h8000_0000, 64'hFFFF_FFFF, 64'd0,        1,  "rem_ovf");
      run(0, enc(OP, 3'b101, F7M), 64'h8000_0000, 64'hFFFF_FFFF, 64'd0,        33, "divu_no_ovf");

      // RV32, 3-stage multiplier, radix-4 divider
      run(1, enc(OP, 3'b101, F7M), 64'd100,      64'd7,         64'd14,        17, "r4_divu_100_7");
      run(1, enc(OP, 3'b111, F7M), 64'd100,      64'd7,         64'd2,         17, "r4_remu_100_7");
      run(1, enc(OP, 3'b100, F7M), 64'd7,        64'hFFFF_FFFE, 64'hFFFF_FFFD, 17, "r4_div_7_m2");
      run(1, enc(OP, 3'b000, F7M), 64'd3,        64'd4,         64'd12,        3,  "s3_mul_3_4");

      // RV64 with W-ops
      run(2, enc(OPW, 3'b100, F7M), 64'hDEAD_BEEF_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33, "divw_m8_3");
      run(2, enc(OPW, 3'b110, F7M), 64'hDEAD_BEEF_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33, "remw_m8_3");
      run(2, enc(OPW, 3'b000, F7M), 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 2, "mulw_sext");
      run(2, enc(OPW, 3'b101, F7M), 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'h0000_0000_5555_5552, 33, "divuw");
      run(2, enc(OPW, 3'b111, F7M), 64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'd2, 33, "remuw");
      run(2, enc(OPW, 3'b100, F7M), 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divw_by0");
      run(2, enc(OP, 3'b101, F7M), 64'd1000, 64'd7, 64'd142, 65, "divu64");
      run(2, enc(OP, 3'b011, F7M), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 2, "mulhu64");

      // Reset five cycles into a DIVU aborts it with no stale completion.
      @(negedge clk);
      instr = enc(OP, 3'b101, F7M);
      rs1 = 64'd100;
      rs2 = 64'd7;
      valid_v[0] = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort busy", 64'(busy_v[0]), 64'd0);
      chk("abort ready", 64'(ready_v[0]), 64'd0);
      chk("abort rd", rd_a[0], 64'd0);
      chk("abort state", 64'(st0), 64'd0);
      valid_v[0] = 1'b0;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run(0, enc(OP, 3'b000, F7M), 64'd3, 64'd4, 64'd12, 2, "post_reset_mul");

      // Unclaimed encodings: ADD, W-op on RV32, bad W funct3 on RV64.
      busy_seen = 0;
      @(negedge clk);
      instr = enc(OP, 3'b000, 7'b0000000);
      valid_v[0] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         busy_seen += int'(busy_v[0]);
      end
      instr = enc(OPW, 3'b100, F7M);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         busy_seen += int'(busy_v[0]);
      end
      valid_v[0] = 1'b0;
      instr = enc(OPW, 3'b001, F7M);
      valid_v[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         busy_seen += int'(busy_v[2]);
      end
      valid_v[2] = 1'b0;
      chk("unclaimed busy_cycles", 64'(busy_seen), 64'd0);

      repeat (100) @(negedge clk);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0d cycles", 40000);
      $fatal(1);
   end

endmodule
